schoolbook_digit: RTL and testbench
===================================

// Module: schoolbook_digit
// PURPOSE
//   Digit-serial schoolbook multiplier. Computes the full-width product c = a * b
//   by consuming DW bits of b per clock.
//   Parametrised successor of the single-bit shift-add multiplier, adding:
//     - an explicit start/busy/done handshake
//     - operand capture
//     - a configurable digit width, trading area against latency.
//   Sits alongside the other large-integer multipliers in the library as a low-area option.
// PARAMETERS
//   WA   224  width of operand a in bits (>= 1)
//   WB   224  width of operand b in bits (>= 1)
//   DW   8    bits of b consumed per cycle, 1 <= DW <= WB.
//             ND = ceil(WB/DW) digits per operation.
// PORTS
//   clk    in   1        rising-edge clock
//   rst    in   1        reset; asynchronous, active-low
//   start  in   1        request; sampled only in IDLE
//   a      in   WA       multiplicand; captured on the accepted start edge
//   b      in   WB       multiplier; captured on the accepted start edge
//   busy   out  1        high while an operation is in progress (RUN)
//   done   out  1        one-cycle pulse; c holds a new result
//   c      out  WA+WB    product register; holds until the next completion
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE; busy=0, done=0, c=0.
//   Digit counter, captured operands and accumulator are all cleared.
//   Reset aborts any operation in flight; no done is issued for it.
// - States: IDLE, RUN.
//   - IDLE & start=1 at an edge:
//     - capture a_r=a and b_r=b (b zero-extended to ND*DW bits)
//     - acc=0, cnt=0, go to RUN, busy=1
//   - IDLE & start=0: stay in IDLE.
//   - RUN, each edge:
//     - acc += (a_r * b_r[DW*cnt +: DW]) << (DW*cnt); cnt += 1
//     - on the edge processing digit ND-1:
//       - c <= final acc
//       - done=1 for exactly that following cycle
//       - busy=0, go to IDLE
// - Latency: start accepted at edge E, so c/done are updated at edge E+ND.
//   done is visible during the cycle after E+ND. Throughput is one operation per ND+1 cycles.
// - start while busy=1 is ignored (not queued). a and b may change freely after the accepted edge.
// - start=1 during the done cycle is accepted (state is IDLE).
//   The new operation begins; c keeps the just-finished result until its own completion.
// - done is never asserted together with busy.
// - Arithmetic:
//   - acc is WA+WB bits wide; the exact product always fits, so there is no truncation.
//   - Partial product a_r*digit is WA+DW bits.
//   - The final digit may be partial when WB%DW != 0; its padding bits are zero.
// - Zero operands still take the full ND cycles; no early termination.
// - DW=1 reproduces the bit-serial schedule (ND=WB) with the handshake added.
// TESTING
// - T1 WA=WB=224, DW=8: a=b=2^224-1, start 1 cycle.
//   -> busy for 28 cycles, done 1 cycle; c = 2^448 - 2^225 + 1.
// - T2 defaults: a=0, b=2^224-1, then a=5, b=7.
//   -> c=0 after 28 cycles; then c=35 after 28 cycles; same latency both times.
// - T3 WA=WB=10, DW=4 (partial last digit, ND=3): a=b=1023.
//   -> done at edge E+3; c=1046529.
// - T4 handshake, a=3, b=4:
//   - hold start=1 across the whole RUN -> exactly one result (c=12)
//   - start=1 in the done cycle with a=6, b=9 -> second op accepted
//   - c stays 12 until the next done, then 54
// - T5 reset mid-operation: assert rst=0 asynchronously (between edges) 5 cycles into RUN.
//   -> busy, done and c drop to 0 immediately; no done follows.
//   -> after release, a=2, b=3 gives c=6 with normal latency.
// - T6 random sweep: 1000 random a,b for DW in {1, 7, 8, 32, 224}.
//   -> c equals the golden model a*b; cycles start->done equal ND.

Source files
------------

// File: rtl/schoolbook_digit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | schoolbook_digit : digit-serial schoolbook multiplier, DW bits of b/clk  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module schoolbook_digit #(
  parameter int WA = 224,
  parameter int WB = 224,
  parameter int DW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WA-1:0]        a,
  input  logic [WB-1:0]        b,
  output logic                 busy,
  output logic                 done,
  output logic [WA+WB-1:0]     c
);

  localparam int ND = (WB + DW - 1) / DW;
  localparam int BW = ND * DW;
  localparam int CW = (ND > 1) ? $clog2(ND) : 1;
  localparam int W  = WA + WB;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [WA-1:0]    a_r;
  logic [BW-1:0]    b_r;
  logic [W-1:0]     acc;
  logic [W-1:0]     acc_nxt;
  logic [CW-1:0]    cnt;
  logic             last;
  logic [WA+DW-1:0] pp;
  logic [W-1:0]     pp_sh;

  // b_r shifts right each digit, so the current digit is always its low DW bits.
  always_comb begin
    last    = (cnt == CW'(ND - 1));
    pp      = {{DW{1'b0}}, a_r} * {{WA{1'b0}}, b_r[DW-1:0]};
    pp_sh   = W'(pp) << (DW * int'(cnt));
    acc_nxt = acc + pp_sh;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last)  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_r  <= '0;
      b_r  <= '0;
      acc  <= '0;
      cnt  <= '0;
      c    <= '0;
      done <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_r <= a;
            b_r <= BW'(b);
            acc <= '0;
            cnt <= '0;
          end
        end
        S_RUN: begin
          acc  <= acc_nxt;
          cnt  <= cnt + CW'(1);
          b_r  <= b_r >> DW;
          done <= last;
          if (last) c <= acc_nxt;
        end
        default: done <= 1'b0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_schoolbook_digit.sv
`default_nettype none
// Directed bench for schoolbook_digit: default 224x224/DW=8, 10x10/DW=4 and 8x8/DW=1.
module tb_schoolbook_digit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         start_m = 1'b0;
  logic [223:0] a_m = '0, b_m = '0;
  logic         busy_m, done_m;
  logic [447:0] c_m;

  logic         start_3 = 1'b0;
  logic [9:0]   a_3 = '0, b_3 = '0;
  logic         busy_3, done_3;
  logic [19:0]  c_3;

  logic         start_1 = 1'b0;
  logic [7:0]   a_1 = '0, b_1 = '0;
  logic         busy_1, done_1;
  logic [15:0]  c_1;

  schoolbook_digit #(.WA(224), .WB(224), .DW(8)) u_main (
    .clk(clk), .rst(rst), .start(start_m), .a(a_m), .b(b_m),
    .busy(busy_m), .done(done_m), .c(c_m));

  schoolbook_digit #(.WA(10), .WB(10), .DW(4)) u_part (
    .clk(clk), .rst(rst), .start(start_3), .a(a_3), .b(b_3),
    .busy(busy_3), .done(done_3), .c(c_3));

  schoolbook_digit #(.WA(8), .WB(8), .DW(1)) u_bit (
    .clk(clk), .rst(rst), .start(start_1), .a(a_1), .b(b_1),
    .busy(busy_1), .done(done_1), .c(c_1));

  int checks = 0;
  int errors = 0;
  int which_sel = 0;
  logic         sel_busy, sel_done;
  logic [447:0] sel_c;

  always_comb begin
    sel_busy = busy_m;
    sel_done = done_m;
    sel_c    = c_m;
    case (which_sel)
      1: begin sel_busy = busy_3; sel_done = done_3; sel_c = 448'(c_3); end
      2: begin sel_busy = busy_1; sel_done = done_1; sel_c = 448'(c_1); end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [447:0] obs, input logic [447:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int which, input logic [223:0] av, input logic [223:0] bv,
                       input logic s);
    case (which)
      1:       begin a_3 = av[9:0]; b_3 = bv[9:0]; start_3 = s; end
      2:       begin a_1 = av[7:0]; b_1 = bv[7:0]; start_1 = s; end
      default: begin a_m = av;      b_m = bv;      start_m = s; end
    endcase
  endtask

  // One start pulse; operands are scrambled right after acceptance to prove capture.
  task automatic run_op(input int which, input logic [223:0] av, input logic [223:0] bv,
                        input logic [447:0] ec, input int nd, input string tag);
    int k;
    int nb;
    which_sel = which;
    drive(which, av, bv, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive(which, ~av, ~bv, 1'b0);
    k  = 0;
    nb = 0;
    while (!sel_done && k < 300) begin
      if (sel_busy) nb++;
      @(negedge clk);
      k++;
    end
    chk({tag, ".latency"}, 448'(k), 448'(nd));
    chk({tag, ".busy_cycles"}, 448'(nb), 448'(nd));
    chk({tag, ".busy_at_done"}, 448'(sel_busy), 448'(0));
    chk({tag, ".c"}, sel_c, ec);
    @(negedge clk);
    chk({tag, ".done_pulse"}, 448'(sel_done), 448'(0));
  endtask

  logic [447:0] exp_c;
  logic [223:0] top_bit;
  int k;
  int ndone;
  logic held;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset.busy", 448'({busy_m, busy_3, busy_1}), 448'(0));
    chk("reset.done", 448'({done_m, done_3, done_1}), 448'(0));
    chk("reset.c", c_m, 448'(0));
    rst = 1'b1;
    @(negedge clk);

    // T1: all-ones operands
    exp_c = '1 - (448'(1) << 225) + 448'd2;
    run_op(0, '1, '1, exp_c, 28, "t1_ones");

    // T2: zero operand still takes full latency, then a small product
    run_op(0, 224'd0, '1, 448'd0, 28, "t2_zero");
    run_op(0, 224'd5, 224'd7, 448'd35, 28, "t2_5x7");

    top_bit = 224'd1 << 223;
    run_op(0, top_bit, top_bit, 448'd1 << 446, 28, "msb_x_msb");

    // T3: partial last digit and bit-serial instance
    run_op(1, 224'd1023, 224'd1023, 448'd1046529, 3, "t3_1023sq");
    run_op(1, 224'd1, 224'd512, 448'd512, 3, "t3_top_digit");
    run_op(2, 224'd255, 224'd255, 448'd65025, 8, "dw1_255sq");
    run_op(2, 224'd13, 224'd11, 448'd143, 8, "dw1_13x11");

    // T4a: start held through RUN yields one result
    which_sel = 0;
    a_m = 224'd3; b_m = 224'd4; start_m = 1'b1;
    @(posedge clk);
    @(negedge clk);
    k = 0;
    while (!done_m && k < 300) begin
      @(negedge clk);
      k++;
    end
    start_m = 1'b0;
    chk("t4_hold.latency", 448'(k), 448'd28);
    chk("t4_hold.c", c_m, 448'd12);
    ndone = 0;
    repeat (35) begin
      @(negedge clk);
      if (done_m || busy_m) ndone++;
    end
    chk("t4_hold.no_second_op", 448'(ndone), 448'd0);

    // T4b: start in the done cycle is accepted; c holds until the new completion
    run_op(0, 224'd3, 224'd4, 448'd12, 28, "t4_first");
    a_m = 224'd3; b_m = 224'd4; start_m = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_m = 1'b0;
    k = 0;
    while (!done_m && k < 300) begin
      @(negedge clk);
      k++;
    end
    a_m = 224'd6; b_m = 224'd9; start_m = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_m = 1'b0;
    a_m = '0; b_m = '0;
    chk("t4_b2b.busy_after_done", 448'(busy_m), 448'd1);
    k = 0;
    held = 1'b1;
    while (!done_m && k < 300) begin
      if (c_m !== 448'd12) held = 1'b0;
      @(negedge clk);
      k++;
    end
    chk("t4_b2b.c_held", 448'(held), 448'd1);
    chk("t4_b2b.latency", 448'(k), 448'd28);
    chk("t4_b2b.c", c_m, 448'd54);
    @(negedge clk);

    // T5: asynchronous reset mid-operation
    a_m = 224'd5; b_m = 224'd7; start_m = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_m = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t5_reset.busy", 448'(busy_m), 448'd0);
    chk("t5_reset.done", 448'(done_m), 448'd0);
    chk("t5_reset.c", c_m, 448'd0);
    @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    repeat (35) begin
      @(negedge clk);
      if (done_m) ndone++;
    end
    chk("t5_reset.no_done", 448'(ndone), 448'd0);
    run_op(0, 224'd2, 224'd3, 448'd6, 28, "t5_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
